// File: rtl/ram_init_pkg.sv
// Shared types, encodings and the fill-pattern function for the RAM initialisation controller.
package ram_init_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FILL = 2'd1;
    localparam state_t ST_HOLD = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        MODE_CONST = 2'b00,
        MODE_ADDR  = 2'b01,
        MODE_NADDR = 2'b10
    } mode_e;

    // Patterns are built at this width and truncated by the caller, so DATA_WIDTH may not exceed it.
    localparam int PAT_W = 64;

    function automatic logic [PAT_W-1:0] init_pattern(
        input logic [1:0]       mode,
        input logic [PAT_W-1:0] addr,
        input logic [PAT_W-1:0] fill
    );
        case (mode)
            MODE_ADDR:  return addr;
            MODE_NADDR: return ~addr;
            default:    return fill;
        endcase
    endfunction

endpackage

// File: rtl/ram_init_if.sv
// RAM-side write bus driven by the initialisation controller.
interface ram_init_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) ();

    logic                  init_we;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic [DATA_WIDTH-1:0] init_data;
    logic                  wr_ready;

    modport master (
        output init_we,
        output init_addr,
        output init_data,
        input  wr_ready
    );

    modport slave (
        input  init_we,
        input  init_addr,
        input  init_data,
        output wr_ready
    );

endinterface

// File: rtl/ram_init_pattern.sv
// Combinational fill-word generator: address (zero-extended/truncated), its inverse, or the constant.
module ram_init_pattern
    import ram_init_pkg::*;
#(
    parameter int               ADDR_WIDTH = 8,
    parameter int               DATA_WIDTH = 16,
    parameter logic [PAT_W-1:0] INIT_VALUE = '0
) (
    input  logic [1:0]            mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    assign data = DATA_WIDTH'(init_pattern(mode, PAT_W'(addr), INIT_VALUE));

endmodule

// File: rtl/ram_init_ctrl.sv
// Sweeps every RAM address once with a mode-selected pattern, then holds cfg_rst for RST_HOLD cycles.
module ram_init_ctrl
    import ram_init_pkg::*;
#(
    parameter int               ADDR_WIDTH = 8,
    parameter int               DEPTH      = 256,
    parameter int               DATA_WIDTH = 16,
    parameter logic [PAT_W-1:0] INIT_VALUE = '0,
    parameter int               RST_HOLD   = 10
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       start,
    input  logic [1:0] mode,
    ram_init_if.master ram,
    output logic       busy,
    output logic       done,
    output logic       cfg_rst
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam int                    CNT_W     = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0]      HOLD_LAST = CNT_W'((RST_HOLD > 0) ? RST_HOLD - 1 : 0);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_W-1:0]      hold_cnt;
    logic [1:0]            mode_q;
    logic                  was_done;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            addr     <= '0;
            hold_cnt <= '0;
            mode_q   <= MODE_CONST;
            was_done <= 1'b0;
        end else begin
            was_done <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    mode_q <= mode;
                    addr   <= '0;
                    state  <= ST_FILL;
                end
                ST_FILL: begin
                    // Compare before incrementing so a full 2**ADDR_WIDTH sweep never wraps in FILL.
                    if (ram.wr_ready) begin
                        if (addr == LAST_ADDR) begin
                            addr     <= '0;
                            hold_cnt <= '0;
                            state    <= (RST_HOLD == 0) ? ST_DONE : ST_HOLD;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= ST_DONE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    if (start) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram.init_we   = (state == ST_FILL);
    assign ram.init_addr = addr;
    assign busy          = (state != ST_DONE);
    assign cfg_rst       = busy;
    assign done          = (state == ST_DONE) && !was_done;

    ram_init_pattern #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .INIT_VALUE(INIT_VALUE)
    ) u_pattern (
        .mode(mode_q),
        .addr(addr),
        .data(ram.init_data)
    );

endmodule

// File: tb/tb_ram_init_ctrl.sv
// Directed bench for ram_init_ctrl: three configurations share stimulus, one is observed at a time.
module tb_ram_init_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       wr_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    int sel = 0;

    logic [7:0] exp_data [8];

    always #5 clk = ~clk;

    // A: DEPTH 8, hold 4.  B: DEPTH 4, hold 2.  C: DEPTH 8, no hold.
    ram_init_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) a_bus ();
    ram_init_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) b_bus ();
    ram_init_if #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) c_bus ();

    assign a_bus.wr_ready = wr_ready;
    assign b_bus.wr_ready = wr_ready;
    assign c_bus.wr_ready = wr_ready;

    logic a_busy, a_done, a_cfg;
    logic b_busy, b_done, b_cfg;
    logic c_busy, c_done, c_cfg;

    ram_init_ctrl #(.ADDR_WIDTH(3), .DEPTH(8), .DATA_WIDTH(8), .INIT_VALUE(64'hA5), .RST_HOLD(4)) u_a (
        .sys_clk(clk), .sys_rst(rst), .start(start), .mode(mode), .ram(a_bus),
        .busy(a_busy), .done(a_done), .cfg_rst(a_cfg)
    );

    ram_init_ctrl #(.ADDR_WIDTH(2), .DEPTH(4), .DATA_WIDTH(8), .INIT_VALUE(64'hA5), .RST_HOLD(2)) u_b (
        .sys_clk(clk), .sys_rst(rst), .start(start), .mode(mode), .ram(b_bus),
        .busy(b_busy), .done(b_done), .cfg_rst(b_cfg)
    );

    ram_init_ctrl #(.ADDR_WIDTH(3), .DEPTH(8), .DATA_WIDTH(8), .INIT_VALUE(64'hA5), .RST_HOLD(0)) u_c (
        .sys_clk(clk), .sys_rst(rst), .start(start), .mode(mode), .ram(c_bus),
        .busy(c_busy), .done(c_done), .cfg_rst(c_cfg)
    );

    logic       obs_we, obs_busy, obs_done, obs_cfg;
    logic [7:0] obs_addr, obs_data;

    always_comb begin
        obs_we   = 1'b0;
        obs_addr = '0;
        obs_data = '0;
        obs_busy = 1'b0;
        obs_done = 1'b0;
        obs_cfg  = 1'b0;
        case (sel)
            0: begin
                obs_we = a_bus.init_we; obs_addr = 8'(a_bus.init_addr); obs_data = a_bus.init_data;
                obs_busy = a_busy; obs_done = a_done; obs_cfg = a_cfg;
            end
            1: begin
                obs_we = b_bus.init_we; obs_addr = 8'(b_bus.init_addr); obs_data = b_bus.init_data;
                obs_busy = b_busy; obs_done = b_done; obs_cfg = b_cfg;
            end
            default: begin
                obs_we = c_bus.init_we; obs_addr = 8'(c_bus.init_addr); obs_data = c_bus.init_data;
                obs_busy = c_busy; obs_done = c_done; obs_cfg = c_cfg;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Holds reset for two edges, checks the reset outputs, releases at a falling edge (cycle 0 follows).
    task automatic do_reset(input string tag);
        rst = 1'b1;
        start = 1'b0;
        wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk({tag, "_rst_we"},   32'(obs_we),   0);
        chk({tag, "_rst_addr"}, 32'(obs_addr), 0);
        chk({tag, "_rst_busy"}, 32'(obs_busy), 1);
        chk({tag, "_rst_cfg"},  32'(obs_cfg),  1);
        chk({tag, "_rst_done"}, 32'(obs_done), 0);
        rst = 1'b0;
    endtask

    // Pulses start while in DONE with a new mode; the following cycle is IDLE (cycle 0 of the next sweep).
    task automatic restart(input string tag, input logic [1:0] new_mode);
        start = 1'b1;
        mode = new_mode;
        @(negedge clk);
        chk({tag, "_idle_cfg"},  32'(obs_cfg),  1);
        chk({tag, "_idle_busy"}, 32'(obs_busy), 1);
        chk({tag, "_idle_we"},   32'(obs_we),   0);
        chk({tag, "_idle_done"}, 32'(obs_done), 0);
        start = 1'b0;
    endtask

    // Entered at the falling edge of the IDLE cycle (cycle 0); checks every cycle through exp_done+2.
    task automatic sweep(input string tag, input int depth, input int stall_addr, input int stall_n,
                         input bit pulse_start, input int exp_done);
        int idx = 0;
        int stall_left = stall_n;
        bit ready;
        chk({tag, "_c0_we"},  32'(obs_we),  0);
        chk({tag, "_c0_cfg"}, 32'(obs_cfg), 1);
        wr_ready = 1'b1;
        for (int cyc = 1; cyc <= exp_done + 2; cyc++) begin
            @(negedge clk);
            if (pulse_start) start = (cyc == 2);
            ready = 1'b1;
            if (obs_we && int'(obs_addr) == stall_addr && stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
            end
            wr_ready = ready;
            chk($sformatf("%s_we_c%0d", tag, cyc),   32'(obs_we),   (cyc <= depth + stall_n) ? 1 : 0);
            chk($sformatf("%s_busy_c%0d", tag, cyc), 32'(obs_busy), (cyc < exp_done) ? 1 : 0);
            chk($sformatf("%s_cfg_c%0d", tag, cyc),  32'(obs_cfg),  (cyc < exp_done) ? 1 : 0);
            chk($sformatf("%s_done_c%0d", tag, cyc), 32'(obs_done), (cyc == exp_done) ? 1 : 0);
            if (obs_we && idx < depth) begin
                chk($sformatf("%s_addr_c%0d", tag, cyc), 32'(obs_addr), idx);
                chk($sformatf("%s_data_c%0d", tag, cyc), 32'(obs_data), int'(exp_data[idx]));
                if (ready) idx++;
            end
        end
        start = 1'b0;
        wr_ready = 1'b1;
        chk({tag, "_writes"}, 32'(idx), depth);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Address mode, ready always high: done at cycle 13.
        sel = 0;
        mode = 2'b01;
        exp_data = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        do_reset("t1");
        sweep("t1", 8, -1, 0, 1'b0, 13);

        // Three-cycle stall at address 5 delays done by three cycles.
        do_reset("t2");
        sweep("t2", 8, 5, 3, 1'b0, 16);

        // Constant mode with start pulsed mid-FILL (ignored), then restart in address mode.
        mode = 2'b00;
        exp_data = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        do_reset("t5a");
        sweep("t5a", 8, -1, 0, 1'b1, 13);
        exp_data = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        restart("t5b", 2'b01);
        sweep("t5b", 8, -1, 0, 1'b0, 13);

        // Reset asserted at address 3 aborts the sweep; the next sweep is complete from address 0.
        mode = 2'b01;
        do_reset("t4");
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (obs_we && obs_addr == 8'd3) break;
        end
        chk("t4_reached_addr3", 32'(obs_addr), 3);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_abort_we",   32'(obs_we),   0);
        chk("t4_abort_cfg",  32'(obs_cfg),  1);
        chk("t4_abort_busy", 32'(obs_busy), 1);
        chk("t4_abort_addr", 32'(obs_addr), 0);
        rst = 1'b0;
        sweep("t4", 8, -1, 0, 1'b0, 13);

        // DEPTH 4, DATA_WIDTH 8: inverted address, then constant, then mode 11 falls back to constant.
        sel = 1;
        mode = 2'b10;
        exp_data = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00};
        do_reset("t3a");
        sweep("t3a", 4, -1, 0, 1'b0, 7);
        exp_data = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        restart("t3b", 2'b00);
        sweep("t3b", 4, -1, 0, 1'b0, 7);
        restart("t3c", 2'b11);
        sweep("t3c", 4, -1, 0, 1'b0, 7);

        // No hold stage: done at cycle 9, address cleared after FILL.
        sel = 2;
        mode = 2'b01;
        exp_data = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        do_reset("t6");
        sweep("t6", 8, -1, 0, 1'b0, 9);
        chk("t6_addr_after", 32'(obs_addr), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
